// File: rtl/distance_poll_master.sv
// Periodic bus poller for the ultrasonic distance peripheral: reads STATUS, then DISTANCE, and
// publishes a distance sample plus a car-present flag with hysteresis. Define DIST_AVG_EN to average the last 4 samples.
module distance_poll_master #(
  parameter logic [15:0] STATUS_ADDR      = 16'h0904,
  parameter logic [15:0] DISTANCE_ADDR    = 16'h0900,
  parameter int unsigned POLL_PERIOD      = 50000,
  parameter int unsigned READ_WAIT        = 1,
  parameter int unsigned MAX_STATUS_TRIES = 8,
  parameter logic [15:0] CAR_THRESHOLD    = 16'd100,
  parameter logic [15:0] HYST             = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        io_select,
  output logic [15:0] address,
  input  logic [15:0] read_data,
  output logic [15:0] distance,
  output logic        distance_valid,
  output logic        car_present,
  output logic        timeout_err,
  output logic        busy
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned RW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int unsigned TW = (MAX_STATUS_TRIES > 1) ? $clog2(MAX_STATUS_TRIES) : 1;
  localparam logic [16:0] RELEASE_LVL = 17'(CAR_THRESHOLD) + 17'(HYST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STAT,
    S_GAP,
    S_DIST,
    S_UPD
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [RW-1:0] rw_q, rw_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          stat_ok_q, stat_ok_d;
  logic          io_select_d;
  logic [15:0]   address_d;
  logic [15:0]   distance_d;
  logic          distance_valid_d;
  logic          car_present_d;
  logic          timeout_err_d;
  logic          busy_d;

  logic          rw_last_c;
  logic          sample_c;
  logic [15:0]   pub_c;

  assign rw_last_c = (rw_q == RW'(READ_WAIT - 1));
  assign sample_c  = (state_q == S_DIST) && rw_last_c;

`ifdef DIST_AVG_EN
  // Three previous raw samples; together with the incoming one they form the 4-sample window.
  logic [15:0] hist_q [3];
  logic        primed_q;
  logic [17:0] sum_c;

  always_comb begin
    if (primed_q) begin
      sum_c = 18'(read_data) + 18'(hist_q[0]) + 18'(hist_q[1]) + 18'(hist_q[2]);
    end else begin
      sum_c = {read_data, 2'b00};
    end
    pub_c = sum_c[17:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) hist_q[i] <= 16'd0;
      primed_q <= 1'b0;
    end else if (sample_c) begin
      if (primed_q) begin
        hist_q[2] <= hist_q[1];
        hist_q[1] <= hist_q[0];
        hist_q[0] <= read_data;
      end else begin
        for (int i = 0; i < 3; i++) hist_q[i] <= read_data;
      end
      primed_q <= 1'b1;
    end
  end
`else
  assign pub_c = read_data;
`endif

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d          = state_q;
    period_d         = period_q;
    rw_d             = rw_q;
    tries_d          = tries_q;
    stat_ok_d        = stat_ok_q;
    address_d        = address;
    distance_d       = distance;
    distance_valid_d = 1'b0;
    car_present_d    = car_present;
    timeout_err_d    = timeout_err;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_WAIT;
          period_d = PW'(POLL_PERIOD - 1);
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (period_q == '0) begin
          state_d = S_STAT;
          tries_d = '0;
          rw_d    = '0;
        end else begin
          period_d = period_q - PW'(1);
        end
      end
      S_STAT: begin
        if (rw_last_c) begin
          stat_ok_d = read_data[0];
          rw_d      = '0;
          state_d   = S_GAP;
        end else begin
          rw_d = rw_q + RW'(1);
        end
      end
      S_GAP: begin
        if (stat_ok_q) begin
          state_d = S_DIST;
        end else if (tries_q != TW'(MAX_STATUS_TRIES - 1)) begin
          tries_d = tries_q + TW'(1);
          state_d = S_STAT;
        end else begin
          timeout_err_d = 1'b1;
          if (enable) begin
            state_d  = S_WAIT;
            period_d = PW'(POLL_PERIOD - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DIST: begin
        if (rw_last_c) begin
          distance_d       = pub_c;
          distance_valid_d = 1'b1;
          timeout_err_d    = 1'b0;
          if (!car_present && (17'(pub_c) <= 17'(CAR_THRESHOLD))) begin
            car_present_d = 1'b1;
          end else if (car_present && (17'(pub_c) > RELEASE_LVL)) begin
            car_present_d = 1'b0;
          end
          rw_d    = '0;
          state_d = S_UPD;
        end else begin
          rw_d = rw_q + RW'(1);
        end
      end
      S_UPD: begin
        if (enable) begin
          state_d  = S_WAIT;
          period_d = PW'(POLL_PERIOD - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs follow the state being entered so they line up with it once registered.
    io_select_d = (state_d == S_STAT) || (state_d == S_DIST);
    if (state_d == S_STAT) address_d = STATUS_ADDR;
    if (state_d == S_DIST) address_d = DISTANCE_ADDR;
    busy_d = (state_d == S_STAT) || (state_d == S_GAP) ||
             (state_d == S_DIST) || (state_d == S_UPD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      period_q       <= '0;
      rw_q           <= '0;
      tries_q        <= '0;
      stat_ok_q      <= 1'b0;
      io_select      <= 1'b0;
      address        <= 16'd0;
      distance       <= 16'd0;
      distance_valid <= 1'b0;
      car_present    <= 1'b0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      rw_q           <= rw_d;
      tries_q        <= tries_d;
      stat_ok_q      <= stat_ok_d;
      io_select      <= io_select_d;
      address        <= address_d;
      distance       <= distance_d;
      distance_valid <= distance_valid_d;
      car_present    <= car_present_d;
      timeout_err    <= timeout_err_d;
      busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_distance_poll_master.sv
// Scoreboard bench for distance_poll_master: expected bus reads and published samples are queued
// by the stimulus and checked by an independent monitor.
module tb_distance_poll_master;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        io_select;
  logic [15:0] address;
  logic [15:0] read_data;
  logic [15:0] distance;
  logic        distance_valid;
  logic        car_present;
  logic        timeout_err;
  logic        busy;

  logic [15:0] status_word;
  logic [15:0] dist_word;

  typedef struct packed {
    logic [15:0] d;
    logic        car;
    logic        tout;
  } samp_t;

  logic [15:0] exp_addr_q[$];
  samp_t       exp_s_q[$];
  int          rd_cyc_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bus_count = 0;
  int dv_count = 0;
  int dv_cyc = 0;
  int en_cyc = 0;
  logic prev_io = 1'b0;
  logic prev_dv = 1'b0;

  distance_poll_master #(
    .STATUS_ADDR      (16'h0904),
    .DISTANCE_ADDR    (16'h0900),
    .POLL_PERIOD      (4),
    .READ_WAIT        (1),
    .MAX_STATUS_TRIES (8),
    .CAR_THRESHOLD    (16'd100),
    .HYST             (16'd8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .io_select      (io_select),
    .address        (address),
    .read_data      (read_data),
    .distance       (distance),
    .distance_valid (distance_valid),
    .car_present    (car_present),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  // Peripheral model; an idle bus returns all-ones so a stray sample is visible.
  assign read_data = !io_select ? 16'hFFFF :
                     (address == 16'h0904) ? status_word :
                     (address == 16'h0900) ? dist_word : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every read strobe and every sample pulse is matched against the queues.
  always @(negedge clk) begin
    if (io_select) begin
      chk("bus_gap", 32'(prev_io), 32'd0);
      if (exp_addr_q.size() == 0) begin
        chk("bus_unexpected_read", 32'(address), 32'hFFFFFFFF);
      end else begin
        chk("bus_addr", 32'(address), 32'(exp_addr_q.pop_front()));
      end
      rd_cyc_q.push_back(cyc);
      bus_count++;
    end
    prev_io = io_select;
    if (distance_valid) begin
      samp_t e;
      chk("dv_width", 32'(prev_dv), 32'd0);
      if (exp_s_q.size() == 0) begin
        chk("dv_unexpected", 32'(distance), 32'hFFFFFFFF);
      end else begin
        e = exp_s_q.pop_front();
        chk("distance", 32'(distance), 32'(e.d));
        chk("car_present", 32'(car_present), 32'(e.car));
        chk("timeout_err_at_dv", 32'(timeout_err), 32'(e.tout));
      end
      dv_count++;
      dv_cyc = cyc;
    end
    prev_dv = distance_valid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(input int target);
    for (int i = 0; i < 100 && dv_count < target; i++) step();
    chk("dv_seen", 32'(dv_count >= target), 32'd1);
  endtask

  task automatic do_poll(input logic [15:0] d, input logic [15:0] ed, input logic ec);
    int n;
    status_word = 16'h0001;
    dist_word   = d;
    exp_addr_q.push_back(16'h0904);
    exp_addr_q.push_back(16'h0900);
    exp_s_q.push_back({ed, ec, 1'b0});
    rd_cyc_q.delete();
    n      = dv_count;
    en_cyc = cyc;
    enable = 1'b1;
    wait_dv(n + 1);
    enable = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    enable      = 1'b0;
    status_word = 16'h0000;
    dist_word   = 16'h0000;
    repeat (3) step();
    chk("rst_io_select", 32'(io_select), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_distance", 32'(distance), 32'd0);
    chk("rst_dv", 32'(distance_valid), 32'd0);
    chk("rst_car", 32'(car_present), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) step();
    chk("quiet_when_disabled", 32'(bus_count), 32'd0);

`ifdef DIST_AVG_EN
    do_poll(16'd40,  16'd40,  1'b1);
    do_poll(16'd80,  16'd50,  1'b1);
    do_poll(16'd120, 16'd70,  1'b1);
    do_poll(16'd160, 16'd100, 1'b1);
`else
    // Nominal poll with latency checks
    do_poll(16'h0050, 16'h0050, 1'b1);
    chk("nom_read_count", 32'(rd_cyc_q.size()), 32'd2);
    if (rd_cyc_q.size() == 2) begin
      chk("nom_first_read_lat", 32'(rd_cyc_q[0] - en_cyc), 32'd5);
      chk("nom_gap", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd2);
      chk("nom_dv_lat", 32'(dv_cyc - rd_cyc_q[0]), 32'd3);
    end

    // Status timeout: eight status reads, one idle cycle apart, no sample
    status_word = 16'h0000;
    rd_cyc_q.delete();
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(16'h0904);
    n = dv_count;
    enable = 1'b1;
    for (int i = 0; i < 300 && !timeout_err; i++) step();
    enable = 1'b0;
    chk("timeout_set", 32'(timeout_err), 32'd1);
    chk("timeout_reads", 32'(rd_cyc_q.size()), 32'd8);
    if (rd_cyc_q.size() == 8) begin
      chk("timeout_span", 32'(rd_cyc_q[7] - rd_cyc_q[0]), 32'd14);
      chk("timeout_flag_lat", 32'(cyc - rd_cyc_q[7]), 32'd2);
    end
    repeat (10) step();
    chk("timeout_no_dv", 32'(dv_count), 32'(n));
    chk("timeout_reads_consumed", 32'(exp_addr_q.size()), 32'd0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);

    // Recovery clears timeout_err at the distance sample
    do_poll(16'h0050, 16'h0050, 1'b1);
    chk("timeout_cleared", 32'(timeout_err), 32'd0);

    // Hysteresis sequence starting from car_present=1
    do_poll(16'd100, 16'd100, 1'b1);
    do_poll(16'd105, 16'd105, 1'b1);
    do_poll(16'd109, 16'd109, 1'b0);
    do_poll(16'd101, 16'd101, 1'b0);
    do_poll(16'd100, 16'd100, 1'b1);

    // Reset asserted while a status read is on the bus
    status_word = 16'h0001;
    exp_addr_q.push_back(16'h0904);
    enable = 1'b1;
    for (int i = 0; i < 50 && !io_select; i++) step();
    chk("midstat_reached", 32'(io_select), 32'd1);
    reset = 1'b1;
    #1;
    chk("midstat_io_select", 32'(io_select), 32'd0);
    chk("midstat_distance", 32'(distance), 32'd0);
    chk("midstat_dv", 32'(distance_valid), 32'd0);
    chk("midstat_car", 32'(car_present), 32'd0);
    chk("midstat_timeout", 32'(timeout_err), 32'd0);
    chk("midstat_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    n = bus_count;
    repeat (20) step();
    chk("post_reset_quiet", 32'(bus_count), 32'(n));

    // Enable dropped during DIST: sample still published, then idle
    status_word = 16'h0001;
    dist_word   = 16'd200;
    exp_addr_q.push_back(16'h0904);
    exp_addr_q.push_back(16'h0900);
    exp_s_q.push_back({16'd200, 1'b0, 1'b0});
    n = dv_count;
    enable = 1'b1;
    for (int i = 0; i < 50 && !(io_select && address == 16'h0900); i++) step();
    chk("drop_in_dist", 32'(io_select && address == 16'h0900), 32'd1);
    enable = 1'b0;
    wait_dv(n + 1);
    repeat (3) step();
    chk("drop_busy_low", 32'(busy), 32'd0);
    n = bus_count;
    repeat (20) step();
    chk("drop_no_more_reads", 32'(bus_count), 32'(n));
`endif

    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("sample_queue_empty", 32'(exp_s_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
